alu_pipe: RTL and testbench

//  Parametrised, two-stage pipelined successor of the single-cycle WISC ALU.

---
 rtl/alu_pipe.sv | 182 ++++++++++++++++++
 tb/tb_alu_pipe.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both sides.
// S1 holds the operand beat, S2 holds the computed result. The {Z,N,V} flag
// register commits only when a result is handed off downstream.
module alu_pipe #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned LANE    = 4,
  parameter int unsigned SHAMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             illegal,
  output logic [2:0]       flags
);

  localparam int unsigned NLANE = WIDTH / LANE;
  localparam int unsigned NBYTE = WIDTH / 8;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_XOR    = 4'd1;
  localparam logic [3:0] OP_RED    = 4'd2;
  localparam logic [3:0] OP_SLL    = 4'd3;
  localparam logic [3:0] OP_SRA    = 4'd4;
  localparam logic [3:0] OP_ROR    = 4'd5;
  localparam logic [3:0] OP_PADDSB = 4'd6;
  localparam logic [3:0] OP_LLB    = 4'd7;
  localparam logic [3:0] OP_LHB    = 4'd8;

  // Which flags a beat updates when it is handed off
  localparam logic [1:0] FL_NONE = 2'd0;
  localparam logic [1:0] FL_Z    = 2'd1;
  localparam logic [1:0] FL_ZNV  = 2'd2;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_op;
  logic             r_sub;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_illegal;
  logic [1:0]       r_fcls;
  logic             r_v;
  logic [2:0]       r_flags;

  logic             w_s1_adv;
  logic             w_s2_adv;
  logic [WIDTH-1:0] w_bx;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;
  logic [WIDTH-1:0] w_addsat;
  logic [WIDTH-1:0] w_red;
  logic [WIDTH-1:0] w_padd;
  logic [SHAMT_W-1:0] w_sh;
  logic [SHAMT_W-1:0] w_sh_neg;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_res;
  logic             w_ill;
  logic [1:0]       w_fcls;
  logic             w_v;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  assign out_valid = r_s2_valid;
  assign result    = r_result;
  assign illegal   = r_illegal;
  assign flags     = r_flags;

  // Saturating add/sub: one extra sign bit exposes signed overflow
  assign w_bx     = r_sub ? ~r_b : r_b;
  assign w_sum    = {r_a[WIDTH-1], r_a} + {w_bx[WIDTH-1], w_bx} + {{WIDTH{1'b0}}, r_sub};
  assign w_ovf    = w_sum[WIDTH] ^ w_sum[WIDTH-1];
  assign w_addsat = !w_ovf ? w_sum[WIDTH-1:0]
                  : (w_sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});

  // Per-lane saturating add, no carry between lanes
  for (genvar gl = 0; gl < NLANE; gl++) begin : g_lane
    logic [LANE:0] w_ls;
    assign w_ls = {r_a[gl*LANE+LANE-1], r_a[gl*LANE +: LANE]}
                + {r_b[gl*LANE+LANE-1], r_b[gl*LANE +: LANE]};
    assign w_padd[gl*LANE +: LANE] = (w_ls[LANE] ^ w_ls[LANE-1])
        ? (w_ls[LANE] ? {1'b1, {(LANE-1){1'b0}}} : {1'b0, {(LANE-1){1'b1}}})
        : w_ls[LANE-1:0];
  end

  // Sum of all sign-extended bytes of both operands
  always_comb begin
    w_red = '0;
    for (int unsigned i = 0; i < NBYTE; i++) begin
      w_red = w_red + {{(WIDTH-8){r_a[8*i+7]}}, r_a[8*i +: 8]}
                    + {{(WIDTH-8){r_b[8*i+7]}}, r_b[8*i +: 8]};
    end
  end

  // Rotate as two shifts; the left amount wraps to 0 when the right amount is 0
  assign w_sh     = r_b[SHAMT_W-1:0];
  assign w_sh_neg = '0 - w_sh;
  assign w_ror    = (r_a >> w_sh) | (r_a << w_sh_neg);

  // Result select and flag class for the beat in S1
  always_comb begin
    w_res  = '0;
    w_ill  = 1'b0;
    w_fcls = FL_NONE;
    w_v    = 1'b0;
    case (r_op)
      OP_ADD:    begin w_res = w_addsat; w_fcls = FL_ZNV; w_v = w_ovf; end
      OP_XOR:    begin w_res = r_a ^ r_b; w_fcls = FL_Z; end
      OP_RED:    w_res = w_red;
      OP_SLL:    begin w_res = r_a << w_sh; w_fcls = FL_Z; end
      OP_SRA:    begin w_res = $unsigned($signed(r_a) >>> w_sh); w_fcls = FL_Z; end
      OP_ROR:    begin w_res = w_ror; w_fcls = FL_Z; end
      OP_PADDSB: w_res = w_padd;
      OP_LLB:    w_res = {r_a[WIDTH-1:8], r_b[7:0]};
      OP_LHB:    w_res = {r_b[7:0], r_a[WIDTH-9:0]};
      default:   w_ill = 1'b1;
    endcase
  end

  // Stage S1: capture operand beat when the stage can advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_sub      <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_a   <= a;
        r_b   <= b;
        r_op  <= op;
        r_sub <= sub;
      end
    end
  end

  // Stage S2: capture computed result; held while stalled downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_illegal  <= 1'b0;
      r_fcls     <= FL_NONE;
      r_v        <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result  <= w_res;
        r_illegal <= w_ill;
        r_fcls    <= w_fcls;
        r_v       <= w_v;
      end
    end
  end

  // Flag register: commits on output handshake only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= '0;
    end else if (r_s2_valid && out_ready) begin
      case (r_fcls)
        FL_ZNV:  r_flags <= {r_result == '0, r_result[WIDTH-1], r_v};
        FL_Z:    r_flags[2] <= (r_result == '0);
        default: r_flags <= r_flags;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: table-driven vectors and hand sequences through a scoreboard.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [3:0]  op = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic        illegal;
  logic [2:0]  flags;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(16), .LANE(4), .SHAMT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .illegal(illegal), .flags(flags)
  );

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] res;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] res;
    logic        ill;
    int          cin;
    logic        lat;
  } sb_t;

  vec_t        tab[$];
  sb_t         q[$];
  sb_t         cur;
  logic [2:0]  mflags = '0;
  int          cyc = 0;
  int          npass = 0;
  int          nchk = 0;
  int          stall_lo = 0;
  int          stall_hi = 0;
  logic        ordy_base = 1'b0;
  logic        last_fin = 1'b0;
  logic        saw_nrdy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic fail_now(input string nm);
    nchk++;
    $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
  endtask

  // Reference ALU, written from the operation definitions with integers
  function automatic void model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                                input logic s, output logic [15:0] r, output logic ill);
    int t, u, v;
    int sh;
    r = '0; ill = 1'b0; sh = int'(y[3:0]);
    case (o)
      4'd0: begin
        u = $signed(x); v = $signed(y);
        t = s ? u - v : u + v;
        if (t > 32767) t = 32767;
        if (t < -32768) t = -32768;
        r = t[15:0];
      end
      4'd1: r = x ^ y;
      4'd2: begin
        t = 0;
        for (int k = 0; k < 2; k++) begin
          u = $signed(x[8*k +: 8]); v = $signed(y[8*k +: 8]);
          t = t + u + v;
        end
        r = t[15:0];
      end
      4'd3: r = x << y[3:0];
      4'd4: for (int i = 0; i < 16; i++) r[i] = (i + sh < 16) ? x[i + sh] : x[15];
      4'd5: for (int i = 0; i < 16; i++) r[i] = x[(i + sh) % 16];
      4'd6: for (int l = 0; l < 4; l++) begin
        u = $signed(x[4*l +: 4]); v = $signed(y[4*l +: 4]);
        t = u + v;
        if (t > 7) t = 7;
        if (t < -8) t = -8;
        r[4*l +: 4] = t[3:0];
      end
      4'd7: r = {x[15:8], y[7:0]};
      4'd8: r = {y[7:0], x[7:0]};
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic logic [2:0] flag_next(input logic [2:0] f, input sb_t e);
    int t, u, v;
    logic [2:0] n;
    n = f;
    if (!e.ill) begin
      case (e.op)
        4'd0: begin
          u = $signed(e.a); v = $signed(e.b);
          t = e.sub ? u - v : u + v;
          n = {e.res == 16'h0, e.res[15], (t > 32767) || (t < -32768)};
        end
        4'd1, 4'd3, 4'd4, 4'd5: n[2] = (e.res == 16'h0);
        default: n = f;
      endcase
    end
    return n;
  endfunction

  task automatic drive(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                       input logic s, input logic [15:0] xr, input logic xi, input logic lat);
    op = o; a = x; b = y; sub = s; in_valid = 1'b1;
    cur.op = o; cur.a = x; cur.b = y; cur.sub = s; cur.res = xr; cur.ill = xi; cur.lat = lat;
  endtask

  task automatic drive_m(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                         input logic s);
    logic [15:0] r;
    logic        il;
    model(o, x, y, s, r, il);
    drive(o, x, y, s, r, il, 1'b0);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // One clock cycle, entered and left just after a falling edge
  task automatic step();
    sb_t e;
    logic fin, fout;
    out_ready = ordy_base && !(cyc >= stall_lo && cyc < stall_hi);
    #2;
    fin  = in_valid && in_ready;
    fout = out_valid && out_ready;
    if (in_valid && !in_ready) saw_nrdy = 1'b1;
    if (fout) begin
      if (q.size() == 0) begin
        chk("unexpected_out", {31'd0, out_valid}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("result", {16'd0, result}, {16'd0, e.res});
        chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
        if (e.lat) chk("latency", cyc - e.cin, 2);
        mflags = flag_next(mflags, e);
      end
    end
    if (fin) begin
      cur.cin = cyc;
      q.push_back(cur);
    end
    last_fin = fin;
    @(posedge clk);
    #1;
    chk("flags", {29'd0, flags}, {29'd0, mflags});
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    idle();
    for (int k = 0; k < 20 && q.size() != 0; k++) step();
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic addv(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                      input logic s, input logic [15:0] r, input logic il);
    vec_t v;
    v.op = o; v.a = x; v.b = y; v.sub = s; v.res = r; v.ill = il;
    tab.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    addv(4'd0, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0);
    addv(4'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0);
    addv(4'd0, 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b0);
    addv(4'd0, 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b0);
    addv(4'd0, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b0);
    addv(4'd0, 16'h1234, 16'h8000, 1'b1, 16'h7FFF, 1'b0);
    addv(4'd1, 16'h00F0, 16'h0F0F, 1'b1, 16'h0FFF, 1'b0);
    addv(4'd1, 16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0);
    addv(4'd6, 16'h7878, 16'h1919, 1'b0, 16'h7878, 1'b0);
    addv(4'd6, 16'h1234, 16'h2111, 1'b0, 16'h3345, 1'b0);
    addv(4'd6, 16'h000F, 16'h0001, 1'b0, 16'h0000, 1'b0);
    addv(4'd2, 16'h7F80, 16'h0102, 1'b0, 16'h0002, 1'b0);
    addv(4'd2, 16'h8080, 16'h8080, 1'b0, 16'hFE00, 1'b0);
    addv(4'd2, 16'h7F7F, 16'h7F7F, 1'b0, 16'h01FC, 1'b0);
    addv(4'd3, 16'h1234, 16'hFFF4, 1'b0, 16'h2340, 1'b0);
    addv(4'd3, 16'h0001, 16'h000F, 1'b0, 16'h8000, 1'b0);
    addv(4'd4, 16'h8000, 16'h000F, 1'b0, 16'hFFFF, 1'b0);
    addv(4'd4, 16'h4000, 16'h0002, 1'b0, 16'h1000, 1'b0);
    addv(4'd4, 16'h9000, 16'h0000, 1'b0, 16'h9000, 1'b0);
    addv(4'd5, 16'h0001, 16'h0001, 1'b0, 16'h8000, 1'b0);
    addv(4'd5, 16'h1234, 16'h0004, 1'b0, 16'h4123, 1'b0);
    addv(4'd7, 16'hABCD, 16'h1234, 1'b0, 16'hAB34, 1'b0);
    addv(4'd8, 16'hABCD, 16'h1234, 1'b0, 16'h34CD, 1'b0);
    addv(4'hB, 16'h1234, 16'h0001, 1'b0, 16'h0000, 1'b1);
    addv(4'hF, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b1);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_flags", {29'd0, flags}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single ADD: out_valid exactly two edges after acceptance
    ordy_base = 1'b1;
    drive(4'd0, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b1);
    step();
    idle();
    chk("lat_early", {31'd0, out_valid}, 32'd0);
    step();
    chk("lat_on_time", {31'd0, out_valid}, 32'd1);
    drain();

    // Table stream, back to back, no backpressure
    foreach (tab[i]) begin
      drive(tab[i].op, tab[i].a, tab[i].b, tab[i].sub, tab[i].res, tab[i].ill, 1'b1);
      #1;
      chk("in_ready_stream", {31'd0, in_ready}, 32'd1);
      step();
    end
    drain();

    // Four beats with out_ready low for three cycles mid-stream
    saw_nrdy = 1'b0;
    stall_lo = cyc + 2;
    stall_hi = cyc + 5;
    for (int j = 0; j < 4; j++) begin
      case (j)
        0: drive_m(4'd0, 16'h0001, 16'h0001, 1'b0);
        1: drive_m(4'd0, 16'h0003, 16'h0005, 1'b1);
        2: drive_m(4'd1, 16'h00FF, 16'h0F0F, 1'b0);
        default: drive_m(4'd0, 16'h7000, 16'h7000, 1'b0);
      endcase
      last_fin = 1'b0;
      for (int k = 0; k < 10 && !last_fin; k++) step();
      if (!last_fin) fail_now("stall_accept");
    end
    drain();
    chk("in_ready_dropped", {31'd0, saw_nrdy}, 32'd1);

    // Async reset while a result is stalled at the output
    stall_lo = 0;
    stall_hi = 0;
    drive_m(4'd0, 16'h7FFF, 16'h0001, 1'b0);
    step();
    drain();
    ordy_base = 1'b0;
    drive_m(4'd1, 16'h0001, 16'h0002, 1'b0);
    step();
    idle();
    step();
    chk("stalled_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_result", {16'd0, result}, 32'd0);
    chk("arst_flags", {29'd0, flags}, 32'd0);
    q.delete();
    mflags = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Recovery beat after reset
    ordy_base = 1'b1;
    drive(4'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1);
    step();
    drain();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
